// File: rtl/mem_wb_stage_pkg.sv
// Shared CPU encodings for the MEM/WB writeback path: writeback select, load funct3, FSM states.
package mem_wb_stage_pkg;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [1:0] WB_IMM  = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    ST_RUN       = 1'b0,
    ST_WAIT_LOAD = 1'b1
  } state_e;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Signal bundle between the MEM stage / register bank and mem_wb_stage.
// Optional RETIRE_COUNT_EN adds the oInstret retire counter.
interface mem_wb_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) ();
  logic              iValid;
  logic              iFlush;
  logic              iRegWrite;
  logic [REG_AW-1:0] iRd;
  logic [1:0]        iWBSel;
  logic [DATA_W-1:0] iALUResult;
  logic [DATA_W-1:0] iPC4;
  logic [DATA_W-1:0] iImm;
  logic [2:0]        iFunct3;
  logic [DATA_W-1:0] iMemRData;
  logic              iMemReady;
  logic              oStallReq;
  logic              oRegWrite;
  logic [REG_AW-1:0] oWriteRegister;
  logic [DATA_W-1:0] oWriteData;
  logic              oFwdValid;
  logic              oMisaligned;
`ifdef RETIRE_COUNT_EN
  logic [63:0]       oInstret;
`endif

  modport master (
    output iValid, iFlush, iRegWrite, iRd, iWBSel, iALUResult, iPC4, iImm, iFunct3,
    output iMemRData, iMemReady,
    input  oStallReq, oRegWrite, oWriteRegister, oWriteData, oFwdValid, oMisaligned
`ifdef RETIRE_COUNT_EN
    , input oInstret
`endif
  );

  modport slave (
    input  iValid, iFlush, iRegWrite, iRd, iWBSel, iALUResult, iPC4, iImm, iFunct3,
    input  iMemRData, iMemReady,
    output oStallReq, oRegWrite, oWriteRegister, oWriteData, oFwdValid, oMisaligned
`ifdef RETIRE_COUNT_EN
    , output oInstret
`endif
  );
endinterface

// File: rtl/mem_wb_stage_load_extend.sv
// Combinational load aligner: picks byte/half/word at the offset, sign/zero-extends, flags misalignment.
module load_extend
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] word_i,
  input  logic [1:0]        offset_i,
  input  logic [2:0]        funct3_i,
  output logic [DATA_W-1:0] data_o,
  output logic              misaligned_o
);

  logic [DATA_W-1:0] byte_shift;
  logic [DATA_W-1:0] half_shift;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  always_comb begin
    byte_shift   = word_i >> {offset_i, 3'b000};
    half_shift   = word_i >> {offset_i[1], 4'b0000};
    byte_sel     = byte_shift[7:0];
    half_sel     = half_shift[15:0];
    data_o       = word_i;
    misaligned_o = 1'b0;
    case (funct3_i)
      F3_LB:  data_o = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      F3_LBU: data_o = {{(DATA_W-8){1'b0}}, byte_sel};
      F3_LH: begin
        data_o       = {{(DATA_W-16){half_sel[15]}}, half_sel};
        misaligned_o = offset_i[0];
      end
      F3_LHU: begin
        data_o       = {{(DATA_W-16){1'b0}}, half_sel};
        misaligned_o = offset_i[0];
      end
      F3_LW:   misaligned_o = (offset_i != 2'b00);
      // Reserved load encodings are squashed like misaligned accesses.
      default: misaligned_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: writeback select, load alignment, load-miss stall and forwarding tap.
// Optional RETIRE_COUNT_EN adds a 64-bit retired-instruction counter on oInstret.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input logic            iCLK,
  input logic            iCLR,
  mem_wb_stage_if.slave  bus
);

  state_e            state_q;
  logic [REG_AW-1:0] hold_rd_q;
  logic [2:0]        hold_f3_q;
  logic [1:0]        hold_off_q;
  logic              hold_rw_q;
  logic              regw_q;
  logic [REG_AW-1:0] wreg_q;
  logic [DATA_W-1:0] wdata_q;
  logic              fwd_q;
  logic              mis_q;

  logic              run;
  logic              accept;
  logic              is_load;
  logic [1:0]        ext_off;
  logic [2:0]        ext_f3;
  logic [DATA_W-1:0] ext_data;
  logic              ext_mis;
  logic [DATA_W-1:0] wb_data;
  logic              load_miss;

  assign run     = (state_q == ST_RUN);
  assign accept  = bus.iValid & ~bus.iFlush;
  assign is_load = (bus.iWBSel == WB_LOAD);

  // While waiting, the extractor works from the held metadata instead of the frozen inputs.
  assign ext_off = run ? bus.iALUResult[1:0] : hold_off_q;
  assign ext_f3  = run ? bus.iFunct3 : hold_f3_q;

  load_extend #(
    .DATA_W(DATA_W)
  ) u_load_extend (
    .word_i      (bus.iMemRData),
    .offset_i    (ext_off),
    .funct3_i    (ext_f3),
    .data_o      (ext_data),
    .misaligned_o(ext_mis)
  );

  always_comb begin
    wb_data = bus.iALUResult;
    case (bus.iWBSel)
      WB_LOAD: wb_data = ext_data;
      WB_PC4:  wb_data = bus.iPC4;
      WB_IMM:  wb_data = bus.iImm;
      default: wb_data = bus.iALUResult;
    endcase
  end

  assign load_miss = run & accept & is_load & ~ext_mis & ~bus.iMemReady;

  // Stall drops in the cycle memory answers so upstream advances exactly as the load retires.
  assign bus.oStallReq = ~iCLR & (load_miss | (~run & ~bus.iMemReady));

  always_ff @(posedge iCLK or posedge iCLR) begin
    if (iCLR) begin
      state_q    <= ST_RUN;
      hold_rd_q  <= '0;
      hold_f3_q  <= '0;
      hold_off_q <= '0;
      hold_rw_q  <= 1'b0;
      regw_q     <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
      fwd_q      <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      regw_q  <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
      fwd_q   <= 1'b0;
      mis_q   <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (accept) begin
            if (is_load && ext_mis) begin
              mis_q <= 1'b1;
            end else if (is_load && !bus.iMemReady) begin
              hold_rd_q  <= bus.iRd;
              hold_f3_q  <= bus.iFunct3;
              hold_off_q <= bus.iALUResult[1:0];
              hold_rw_q  <= bus.iRegWrite;
              state_q    <= ST_WAIT_LOAD;
            end else begin
              regw_q  <= bus.iRegWrite;
              wreg_q  <= bus.iRd;
              wdata_q <= wb_data;
              fwd_q   <= bus.iRegWrite & (|bus.iRd);
            end
          end
        end
        ST_WAIT_LOAD: begin
          if (bus.iMemReady) begin
            regw_q  <= hold_rw_q;
            wreg_q  <= hold_rd_q;
            wdata_q <= ext_data;
            fwd_q   <= hold_rw_q & (|hold_rd_q);
            state_q <= ST_RUN;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign bus.oRegWrite      = regw_q;
  assign bus.oWriteRegister = wreg_q;
  assign bus.oWriteData     = wdata_q;
  assign bus.oFwdValid      = fwd_q;
  assign bus.oMisaligned    = mis_q;

`ifdef RETIRE_COUNT_EN
  logic        retire;
  logic [63:0] instret_q;

  assign retire = (run & accept & ~(is_load & (ext_mis | ~bus.iMemReady)))
                | (~run & bus.iMemReady);

  always_ff @(posedge iCLK or posedge iCLR) begin
    if (iCLR) begin
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign bus.oInstret = instret_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized self-checking bench for mem_wb_stage against a queue-based writeback model.
module tb_mem_wb_stage;

  typedef struct {
    logic        valid;
    logic        flush;
    logic        rw;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [31:0] rdata;
    logic        ready;
  } stim_t;

  typedef struct {
    logic [4:0] rd;
    logic [2:0] f3;
    int         off;
    logic       rw;
  } pend_t;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  mem_wb_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

  mem_wb_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .iCLK(clk),
    .iCLR(clr),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model state: expected registered outputs and loads waiting on memory.
  pend_t           pend_q[$];
  logic            m_regw, nx_regw;
  logic [4:0]      m_wreg, nx_wreg;
  logic [31:0]     m_wdata, nx_wdata;
  logic            m_fwd, nx_fwd;
  logic            m_mis, nx_mis;
  longint unsigned m_instret, nx_instret;
  logic            last_stall;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Returns {ok, value}; ok=0 for misaligned or reserved loads.
  function automatic logic [32:0] load_value(input logic [31:0] w, input int off,
                                             input logic [2:0] f3);
    int unsigned b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return {1'b1, (b >= 128) ? b + 32'hFFFF_FF00 : b};
      3'b100:  return {1'b1, b};
      3'b001:  return {(off % 2) == 0, (h >= 32768) ? h + 32'hFFFF_0000 : h};
      3'b101:  return {(off % 2) == 0, h};
      3'b010:  return {off == 0, w};
      default: return {1'b0, 32'h0};
    endcase
  endfunction

  task automatic model_reset();
    pend_q.delete();
    m_regw = 0; m_wreg = 0; m_wdata = 0; m_fwd = 0; m_mis = 0; m_instret = 0;
  endtask

  task automatic model_commit(input logic rw, input logic [4:0] rd, input logic [31:0] d);
    nx_regw = rw; nx_wreg = rd; nx_wdata = d; nx_fwd = rw && (rd != 0);
    nx_instret = m_instret + 1;
  endtask

  task automatic model_step(input stim_t s, output logic exp_stall);
    logic [32:0] lv;
    pend_t p;
    exp_stall = 0;
    nx_regw = 0; nx_wreg = 0; nx_wdata = 0; nx_fwd = 0; nx_mis = 0; nx_instret = m_instret;
    if (pend_q.size() > 0) begin
      if (s.ready) begin
        p  = pend_q.pop_front();
        lv = load_value(s.rdata, p.off, p.f3);
        model_commit(p.rw, p.rd, lv[31:0]);
      end else begin
        exp_stall = 1;
      end
    end else if (s.valid && !s.flush) begin
      if (s.sel == 2'd1) begin
        lv = load_value(s.rdata, int'(s.alu[1:0]), s.f3);
        if (!lv[32]) nx_mis = 1;
        else if (!s.ready) begin
          p.rd = s.rd; p.f3 = s.f3; p.off = int'(s.alu[1:0]); p.rw = s.rw;
          pend_q.push_back(p);
          exp_stall = 1;
        end else model_commit(s.rw, s.rd, lv[31:0]);
      end else begin
        model_commit(s.rw, s.rd, (s.sel == 2'd0) ? s.alu : (s.sel == 2'd2) ? s.pc4 : s.imm);
      end
    end
  endtask

  task automatic drive(input stim_t s);
    bus.iValid = s.valid; bus.iFlush = s.flush; bus.iRegWrite = s.rw; bus.iRd = s.rd;
    bus.iWBSel = s.sel; bus.iALUResult = s.alu; bus.iPC4 = s.pc4; bus.iImm = s.imm;
    bus.iFunct3 = s.f3; bus.iMemRData = s.rdata; bus.iMemReady = s.ready;
  endtask

  function automatic stim_t mk(input logic valid, input logic flush, input logic rw,
                               input logic [4:0] rd, input logic [1:0] sel,
                               input logic [31:0] alu, input logic [2:0] f3,
                               input logic [31:0] rdata, input logic ready);
    stim_t s;
    s.valid = valid; s.flush = flush; s.rw = rw; s.rd = rd; s.sel = sel; s.alu = alu;
    s.pc4 = 32'h0000_0104; s.imm = 32'hABCD_0000; s.f3 = f3; s.rdata = rdata; s.ready = ready;
    return s;
  endfunction

  task automatic check_outputs();
    check_val("regwrite", bus.oRegWrite, m_regw);
    check_val("wreg", bus.oWriteRegister, m_wreg);
    check_val("wdata", bus.oWriteData, m_wdata);
    check_val("fwdvalid", bus.oFwdValid, m_fwd);
    check_val("misaligned", bus.oMisaligned, m_mis);
`ifdef RETIRE_COUNT_EN
    check_val("instret", bus.oInstret, m_instret);
`endif
  endtask

  task automatic run_cycle(input stim_t s);
    logic es;
    @(negedge clk);
    drive(s);
    #1;
    model_step(s, es);
    last_stall = bus.oStallReq;
    check_val("stall", bus.oStallReq, es);
    @(posedge clk);
    #1;
    m_regw = nx_regw; m_wreg = nx_wreg; m_wdata = nx_wdata; m_fwd = nx_fwd; m_mis = nx_mis;
    m_instret = nx_instret;
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_reset();
  endtask

  localparam logic [31:0] WORD = 32'h80FF_7F01;

  initial begin
    stim_t s;
    int    stalls;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_stall", bus.oStallReq, 1'b0);
    check_outputs();
    @(negedge clk);
    clr = 1'b0;

    // ALU writeback
    run_cycle(mk(1, 0, 1, 5, 2'd0, 32'h0000_1234, 3'b010, 0, 1));
    check_val("alu_data", bus.oWriteData, 32'h0000_1234);
    check_val("alu_fwd", bus.oFwdValid, 1'b1);

    // Load extension
    run_cycle(mk(1, 0, 1, 1, 2'd1, 32'h0000_0003, 3'b000, WORD, 1));
    check_val("lb_off3", bus.oWriteData, 32'hFFFF_FF80);
    run_cycle(mk(1, 0, 1, 2, 2'd1, 32'h0000_0002, 3'b100, WORD, 1));
    check_val("lbu_off2", bus.oWriteData, 32'h0000_00FF);
    run_cycle(mk(1, 0, 1, 3, 2'd1, 32'h0000_0002, 3'b001, WORD, 1));
    check_val("lh_off2", bus.oWriteData, 32'hFFFF_80FF);
    run_cycle(mk(1, 0, 1, 4, 2'd1, 32'h0000_0000, 3'b101, WORD, 1));
    check_val("lhu_off0", bus.oWriteData, 32'h0000_7F01);

    // Load miss: three not-ready cycles then data
    stalls = 0;
    for (int i = 0; i < 3; i++) begin
      run_cycle(mk(1, 0, 1, 7, 2'd1, 32'h0000_0100, 3'b010, 32'h0, 0));
      stalls += int'(last_stall);
      check_val("miss_bubble", bus.oRegWrite, 1'b0);
    end
    run_cycle(mk(1, 0, 1, 7, 2'd1, 32'h0000_0100, 3'b010, 32'hDEAD_BEEF, 1));
    stalls += int'(last_stall);
    check_val("miss_stall_cycles", stalls, 3);
    check_val("miss_rd", bus.oWriteRegister, 5'd7);
    check_val("miss_data", bus.oWriteData, 32'hDEAD_BEEF);

    // Misaligned loads
    run_cycle(mk(1, 0, 1, 8, 2'd1, 32'h0000_1002, 3'b010, WORD, 0));
    check_val("mis_lw_stall", last_stall, 1'b0);
    check_val("mis_lw_pulse", bus.oMisaligned, 1'b1);
    run_cycle(mk(0, 0, 0, 0, 2'd0, 0, 3'b000, 0, 1));
    check_val("mis_pulse_end", bus.oMisaligned, 1'b0);
    run_cycle(mk(1, 0, 1, 9, 2'd1, 32'h0000_0001, 3'b001, WORD, 1));
    check_val("mis_lh_pulse", bus.oMisaligned, 1'b1);
    check_val("mis_lh_regw", bus.oRegWrite, 1'b0);

    // rd=0 write and flush over a load miss
    run_cycle(mk(1, 0, 1, 0, 2'd0, 32'h0000_5555, 3'b000, 0, 1));
    check_val("rd0_regw", bus.oRegWrite, 1'b1);
    check_val("rd0_fwd", bus.oFwdValid, 1'b0);
    run_cycle(mk(1, 1, 1, 6, 2'd1, 32'h0, 3'b010, 0, 0));
    check_val("flush_stall", last_stall, 1'b0);
    check_val("flush_bubble", bus.oRegWrite, 1'b0);

    // Asynchronous reset while waiting on a load
    run_cycle(mk(1, 0, 1, 10, 2'd1, 32'h0, 3'b010, 0, 0));
    @(negedge clk);
    drive(mk(1, 0, 1, 10, 2'd1, 32'h0, 3'b010, 0, 0));
    #2;
    clr = 1'b1;
    #1;
    model_reset();
    check_val("clr_stall", bus.oStallReq, 1'b0);
    check_outputs();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    clr = 1'b0;
    run_cycle(mk(1, 0, 1, 11, 2'd2, 32'h0, 3'b000, 0, 1));
    check_val("post_clr_data", bus.oWriteData, 32'h0000_0104);

`ifdef RETIRE_COUNT_EN
    do_reset();
    for (int i = 0; i < 13; i++) begin
      if (i == 3 || i == 8) run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
      else if (i == 5) run_cycle(mk(1, 0, 1, 4, 2'd1, 32'h2, 3'b010, WORD, 1));
      else run_cycle(mk(1, 0, (i % 3) != 0, 5'(i), 2'd0, 32'(i), 3'b000, 0, 1));
    end
    check_val("instret_10", bus.oInstret, 64'd10);
`endif

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      s.valid = ($urandom_range(0, 9) < 8);
      s.flush = ($urandom_range(0, 9) == 0);
      s.rw    = ($urandom_range(0, 3) != 0);
      s.rd    = 5'($urandom_range(0, 31));
      s.sel   = 2'($urandom_range(0, 3));
      s.alu   = $urandom;
      if ($urandom_range(0, 1) == 1) s.alu[1:0] = 2'b00;
      s.pc4   = $urandom;
      s.imm   = $urandom;
      s.f3    = 3'($urandom_range(0, 7));
      s.rdata = $urandom;
      s.ready = ($urandom_range(0, 2) != 0);
      run_cycle(s);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Pipeline stage between the data-memory access stage and the register bank write port.
- Captures the MEM-stage result and aligns and sign/zero-extends load data.
- Selects the writeback source and drives iRegWrite, iWriteRegister and iWriteData of the register bank.
- Stalls the pipeline while a load waits for memory.
- Exports a forwarding tap so ID/EX can bypass the in-flight write.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register address width

Ports:
iCLK  in  1  clock
iCLR  in  1  reset, asynchronous, active-high
iValid  in  1  MEM stage holds a real instruction this cycle
iFlush  in  1  insert bubble (squash incoming instruction)
iRegWrite  in  1  instruction writes rd
iRd  in  REG_AW  destination register
iWBSel  in  2  0=ALU, 1=LOAD, 2=PC+4, 3=IMM
iALUResult  in  DATA_W  ALU result; bits[1:0] are the load byte offset
iPC4  in  DATA_W  PC+4
iImm  in  DATA_W  upper immediate (LUI)
iFunct3  in  3  load width/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
iMemRData  in  DATA_W  raw aligned word from data memory
iMemReady  in  1  iMemRData valid this cycle
oStallReq  out  1  freeze PC/IF/ID/EX/MEM registers
oRegWrite  out  1  to register bank write enable
oWriteRegister  out  REG_AW  to register bank write address
oWriteData  out  DATA_W  to register bank write data
oFwdValid  out  1  forwarding tap valid (oRegWrite & oWriteRegister!=0)
oMisaligned  out  1  one-cycle pulse: misaligned load squashed

Behaviour:
- All outputs registered; reset clears oRegWrite, oWriteRegister, oWriteData, oFwdValid, oMisaligned and oStallReq to 0; FSM resets to RUN.
- Latency: an instruction accepted at posedge N is presented on the outputs from N until N+1.
  - The register bank commits the write on the following negedge in pipelined builds, or the next posedge otherwise.
- FSM states RUN and WAIT_LOAD.
  - RUN, accept (iValid & !iFlush):
    - Non-load, or load with iMemReady=1: compute writeback and capture it; stay in RUN.
    - Load (iWBSel=1) with iMemReady=0: latch rd, funct3, offset and regwrite into a hold register; outputs become a bubble (oRegWrite=0); go to WAIT_LOAD.
  - RUN, no accept (!iValid | iFlush): capture a bubble.
  - WAIT_LOAD: oStallReq=1 (combinational from state), iValid/iFlush ignored, bubble held.
    - On iMemReady=1: capture extended load using the held metadata, go to RUN; oStallReq drops the same cycle.
- oStallReq is also asserted combinationally in RUN when iValid & !iFlush & iWBSel=1 & !iMemReady, so upstream freezes in the cycle the miss is detected.
- Load extraction (offset = iALUResult[1:0]):
  - LB/LBU: byte at offset*8.
  - LH/LHU: halfword at offset[1]*16.
  - LW: whole word.
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
- Misalignment: LH/LHU with offset[0]=1, or LW with offset!=0, or any reserved funct3 with iWBSel=1.
  - Capture a bubble and pulse oMisaligned for exactly one cycle.
  - No stall, no memory wait.
- rd=0: oRegWrite may be 1, but oFwdValid=0 (the register bank ignores writes to register 0).
- iFlush together with a load miss: the flush wins; no stall, bubble captured.
- iCLR asserted in WAIT_LOAD: immediately return to RUN, drop oStallReq, discard the held load.

Optional Feature:
RETIRE_COUNT_EN
- Defined: adds output oInstret [63:0], a counter incremented once per captured non-bubble instruction, including rd=0 writes and stores passed with iRegWrite=0. It is not incremented for bubbles, misaligned squashes, or cycles in WAIT_LOAD. The counter is cleared by iCLR and wraps modulo 2^64.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared CPU package holds:
  - WBSel encodings: WB_ALU=2'd0, WB_LOAD=2'd1, WB_PC4=2'd2, WB_IMM=2'd3.
  - funct3 load codes F3_LB/LH/LW/LBU/LHU.
  - FSM state constants ST_RUN/ST_WAIT_LOAD.
- One sub-module, load_extend: combinational word + offset + funct3 -> extended data + misaligned flag. It is reused by the multicycle core.

Test Plan:
- Reset: hold iCLR mid-WAIT_LOAD -> every output 0 and FSM in RUN within the same cycle; after release the next instruction is accepted.
- ALU writeback: iValid=1, iWBSel=0, iRd=5, iALUResult=0x0000_1234 -> next cycle oRegWrite=1, oWriteRegister=5, oWriteData=0x0000_1234, oFwdValid=1.
- Load extension:
  - iMemRData=0x80FF_7F01, LB offset 3 -> 0xFFFF_FF80.
  - LBU offset 2 -> 0x0000_00FF.
  - LH offset 2 -> 0xFFFF_80FF.
  - LHU offset 0 -> 0x0000_7F01.
- Load miss: LW rd=7 with iMemReady=0 for 3 cycles, then 1 with 0xDEAD_BEEF -> oStallReq=1 for exactly those 3 cycles; the write to x7 = 0xDEAD_BEEF is presented the cycle after ready.
- Misaligned: LW with iALUResult=0x1002 -> oMisaligned pulses 1 cycle, oRegWrite=0, no stall; LH offset 1 -> same.
- Edge cases: iRd=0 ALU op gives oFwdValid=0. iFlush=1 with a load miss gives no stall and a bubble. With RETIRE_COUNT_EN, 10 instructions, 2 bubbles and 1 misaligned load -> oInstret=10.
